// File: rtl/digit_uart_streamer_pkg.sv
// e2_pkg: ASCII constants, digit width and state encodings shared by the digit streamer
package e2_pkg;
    localparam int DIGIT_W = 4;
    localparam logic [7:0] ASC_ZERO = 8'h30;
    localparam logic [7:0] ASC_PT = 8'h2E;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_ERR = 8'h3F;
    typedef enum logic [2:0] {F_IDLE, F_LOAD, F_DIG, F_PT, F_CR, F_LF} fmt_state_e;
    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
    function automatic logic [7:0] to_ascii(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_W'(9)) ? ASC_ZERO + {{(8-DIGIT_W){1'b0}}, d} : ASC_ERR;
    endfunction
endpackage

// File: rtl/digit_uart_streamer_if.sv
// digit_uart_streamer_if: valid/ready digit stream from the converter into the streamer
interface digit_uart_streamer_if;
    import e2_pkg::*;
    logic digit_valid;
    logic [DIGIT_W-1:0] digit_data;
    logic digit_last;
    logic digit_ready;
    modport master(output digit_valid, digit_data, digit_last, input digit_ready);
    modport slave(input digit_valid, digit_data, digit_last, output digit_ready);
endinterface

// File: rtl/digit_uart_streamer_uart_tx.sv
// uart_tx_core: 8N1 serializer; ready in the last stop-bit cycle so frames can abut
module uart_tx_core import e2_pkg::*; #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       tx
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    uart_state_e state;
    logic [CW-1:0] cnt;
    logic [3:0] idx;
    logic [7:0] sh;
    logic bit_end;
    assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
    assign byte_ready = state == U_IDLE || (state == U_STOP && bit_end);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= U_IDLE;
            cnt <= '0;
            idx <= '0;
            sh <= '0;
            tx <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            state <= U_START;
            cnt <= '0;
            sh <= byte_data;
            tx <= 1'b0;
        end else if (state != U_IDLE) begin
            if (!bit_end) cnt <= cnt + 1'b1;
            else begin
                cnt <= '0;
                case (state)
                    U_START: begin
                        state <= U_DATA;
                        idx <= '0;
                        tx <= sh[0];
                        sh <= sh >> 1;
                    end
                    U_DATA: begin
                        state <= idx == 4'd7 ? U_STOP : U_DATA;
                        idx <= idx + 1'b1;
                        tx <= idx == 4'd7 ? 1'b1 : sh[0];
                        sh <= sh >> 1;
                    end
                    default: state <= U_IDLE;
                endcase
            end
        end
endmodule

// File: rtl/digit_uart_streamer.sv
// digit_uart_streamer: buffers BCD digits and sends them as "d.ddd...\r\n" text over UART 8N1
module digit_uart_streamer import e2_pkg::*; #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD = 115_200,
    parameter int FIFO_DEPTH = 16,
    parameter int DIGITS_PER_LINE = 50
) (
    input  logic clk,
    input  logic rst_n,
    digit_uart_streamer_if.slave dif,
    output logic tx,
    output logic busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(DIGITS_PER_LINE + 1);
    logic [DIGIT_W:0] mem [FIFO_DEPTH];
    logic [DIGIT_W:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic ready_en, push, pop, empty;
    fmt_state_e state;
    logic [7:0] byte_data;
    logic byte_valid, byte_ready, accept, in_flight, first, last_r;
    logic [LW-1:0] frac_cnt, frac_nxt;
    assign empty = count == '0;
    assign head = mem[rd_ptr];
    assign dif.digit_ready = ready_en && count != (AW+1)'(FIFO_DEPTH);
    assign push = dif.digit_valid && dif.digit_ready;
    assign pop = (state == F_IDLE || state == F_LOAD) && !empty;
    assign byte_valid = state inside {F_DIG, F_PT, F_CR, F_LF};
    assign accept = byte_valid && byte_ready;
    assign frac_nxt = frac_cnt + 1'b1;
    assign busy = !empty || state != F_IDLE || in_flight;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {dif.digit_last, dif.digit_data};
    // in_flight covers the final stop-bit cycle, where the core already reports ready
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ready_en <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            in_flight <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            in_flight <= accept || (in_flight && !byte_ready);
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= F_IDLE;
            byte_data <= '0;
            first <= 1'b1;
            last_r <= 1'b0;
            frac_cnt <= '0;
        end else case (state)
            F_IDLE, F_LOAD: begin
                state <= empty ? F_IDLE : F_DIG;
                if (!empty) begin
                    byte_data <= to_ascii(head[DIGIT_W-1:0]);
                    last_r <= head[DIGIT_W];
                end
            end
            F_DIG: if (accept) begin
                if (first) begin
                    first <= 1'b0;
                    frac_cnt <= '0;
                    byte_data <= ASC_PT;
                    state <= F_PT;
                end else if (last_r || frac_nxt == LW'(DIGITS_PER_LINE)) begin
                    frac_cnt <= '0;
                    byte_data <= ASC_CR;
                    state <= F_CR;
                end else begin
                    frac_cnt <= frac_nxt;
                    state <= F_LOAD;
                end
            end
            F_PT: if (accept) begin
                byte_data <= last_r ? ASC_CR : byte_data;
                state <= last_r ? F_CR : F_LOAD;
            end
            F_CR: if (accept) begin
                byte_data <= ASC_LF;
                state <= F_LF;
            end
            default: if (accept) begin
                first <= first || last_r;
                state <= F_LOAD;
            end
        endcase
    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk(clk),
        .rst_n(rst_n),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .tx(tx)
    );
endmodule
